uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Parametrised UART transmit serializer; successor to the fixed 11-bit Tx shift stage.
//  Builds start/data/parity/stop framing internally from a parallel word; no pre-built frame.
//  Runs on the system clock, with one bit time per BaudTick enable pulse.
//  Accepts words through a valid/ready handshake and sits between the Tx FIFO and the pad.
// PARAMETERS
//  MaxDataBits   8   widest supported data field; legal range 5..9
//  LenW          4   width of the DataLength port; must hold MaxDataBits
// PORTS
//  Clock         in   1            system clock; all logic on posedge
//  Reset         in   1            synchronous, active-high reset
//  BaudTick      in   1            one-cycle enable; one pulse marks one bit time
//  ParityType    in   2            01 odd, 10 even, 00/11 no parity bit in frame
//  StopBits      in   1            0: one stop bit, 1: two stop bits
//  DataLength    in   LenW         number of data bits, 5..MaxDataBits
//  TxData        in   MaxDataBits  word to send, LSB first; bits above DataLength ignored
//  TxValid       in   1            TxData and config are valid
//  TxReady       out  1            high in IDLE only; accept = TxValid & TxReady at posedge
//  DataOut       out  1            serial line, registered; idle high
//  ParallParOut  out  1            odd parity of the latched data when ParityType is 00/11, else 0
//  ActiveFlag    out  1            high from accept until the end of the last stop bit
//  DoneFlag      out  1            one-cycle pulse after the last stop bit completes
// BEHAVIOUR
//  Reset: DataOut=1, TxReady=1, ActiveFlag=0, DoneFlag=0, ParallParOut=0, state IDLE, counters 0.
//  Reset mid-frame: abort at that edge with the values above; no DoneFlag pulse.
//  FSM states: IDLE -> SYNC -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: on accept, latch TxData, ParityType, StopBits and DataLength; compute ParallParOut;
//     ActiveFlag=1; go to SYNC. Input changes after accept do not affect the frame.
//   SYNC: line stays 1. A BaudTick in the accept cycle is ignored.
//     On the first BaudTick after accept: DataOut<=0, go to START.
//   START: on BaudTick, DataOut<=data[0], bitcnt<=1, go to DATA.
//   DATA: on BaudTick, if bitcnt<N: DataOut<=data[bitcnt], bitcnt++.
//     Otherwise go to PARITY (DataOut<=parity bit) or to STOP (DataOut<=1).
//   PARITY: on BaudTick, DataOut<=1, go to STOP.
//   STOP: holds 1 for S bit times (S = 1 or 2). On the BaudTick ending the last stop bit:
//     IDLE, ActiveFlag<=0, DoneFlag<=1 for one cycle, TxReady<=1.
//  N = DataLength clamped: values <5 act as 5; values >MaxDataBits act as MaxDataBits.
//  Parity over the N latched bits. Odd: bit makes total ones odd. Even: total ones even.
//  Frame = 1+N+P+S bit times; every bit lasts exactly one BaudTick interval.
//  Back-to-back: the next accept happens no earlier than the cycle after DoneFlag.
//  Its start bit begins at the next BaudTick, so there is at least one idle bit time between frames.
//  BaudTick with no frame in progress has no effect. TxValid is ignored while TxReady=0.
//  ParallParOut keeps its value until the next accept; it is cleared only by Reset.
// STRUCTURE
//  Package uart_pkg: ParityType encodings (PAR_NONE0/ODD/EVEN/NONE3), FSM state enum,
//  MIN_DATA_BITS=5.
//  Sub-module uart_parity_gen: combinational odd/even parity over MaxDataBits with a length mask.
//  Used for both the frame parity bit and ParallParOut.
//  Main body: FSM, bit counter (LenW bits), stop counter (1 bit), data and config holding registers.
// TESTING
//  8N1, TxData=0xA5 -> per tick DataOut 0,1,0,1,0,0,1,0,1,1; then DoneFlag pulse; ParallParOut=1.
//  8E2, TxData=0x5A -> 0,0,1,0,1,1,0,1,0, parity 0, stop 1,1; ActiveFlag high for 12 bit times.
//  7O1, TxData=0xC1 -> 7 data bits 1,0,0,0,0,0,1; parity 1; bit 7 of TxData never driven.
//  DataLength=3 and DataLength=12 -> framed as 5 and MaxDataBits data bits respectively.
//  Reset asserted during the DATA bit 3 -> next cycle DataOut=1, TxReady=1, no DoneFlag.
//  Hold TxValid=1 for two words; change config after accept -> second start bit one idle bit after first stop.
//  First frame is unaffected by the config change.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  // Line parity selection; both "none" encodings produce a frame without a parity bit.
  typedef enum logic [1:0] {
    PAR_NONE0 = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE3 = 2'b11
  } parity_e;

  // Serializer frame states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Narrowest data field the serializer will frame.
  localparam int MIN_DATA_BITS = 5;

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity over the low 'len' bits of a data word.
module uart_parity_gen #(
  parameter int Width = 8,
  parameter int LenW  = 4
) (
  input  logic [Width-1:0] data,
  input  logic [LenW-1:0]  len,
  output logic             odd_bit,
  output logic             even_bit
);

  logic [Width-1:0] masked;

  // Keep only the bits that are actually part of the frame.
  always_comb begin
    masked = '0;
    for (int i = 0; i < Width; i++) begin
      if (i < int'(len)) masked[i] = data[i];
    end
  end

  // Even parity bit makes the total count of ones even; odd is its complement.
  assign even_bit = ^masked;
  assign odd_bit  = ~even_bit;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames a parallel word into start/data/parity/stop bits,
// one bit per BaudTick pulse, with a valid/ready handshake on the word side.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int MaxDataBits = 8,
  parameter int LenW        = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   BaudTick,
  input  logic [1:0]             ParityType,
  input  logic                   StopBits,
  input  logic [LenW-1:0]        DataLength,
  input  logic [MaxDataBits-1:0] TxData,
  input  logic                   TxValid,
  output logic                   TxReady,
  output logic                   DataOut,
  output logic                   ParallParOut,
  output logic                   ActiveFlag,
  output logic                   DoneFlag
);

  state_e state_q, state_d;

  // Per-frame configuration captured at accept.
  logic [MaxDataBits-1:0] data_q;
  parity_e                ptype_q;
  logic                   stop2_q;
  logic [LenW-1:0]        n_q;

  logic [LenW-1:0] bitcnt_q, bitcnt_d;
  logic            stopcnt_q, stopcnt_d;
  logic            dout_q, dout_d;
  logic            active_q, active_d;
  logic            done_q, done_d;
  logic            par_out_q, par_out_d;

  logic                   accept;
  logic [LenW-1:0]        n_in;
  logic [MaxDataBits-1:0] pg_data;
  logic [LenW-1:0]        pg_len;
  logic                   pg_odd, pg_even;
  logic [MaxDataBits-1:0] data_sh;
  logic                   data_bit;
  logic                   par_en, par_bit;
  logic                   in_par_none;

  assign TxReady      = (state_q == ST_IDLE);
  assign accept       = TxValid & TxReady;
  assign DataOut      = dout_q;
  assign ActiveFlag   = active_q;
  assign DoneFlag     = done_q;
  assign ParallParOut = par_out_q;

  // Clamp the requested data length into the supported range.
  always_comb begin
    if (DataLength < LenW'(MIN_DATA_BITS))    n_in = LenW'(MIN_DATA_BITS);
    else if (DataLength > LenW'(MaxDataBits)) n_in = LenW'(MaxDataBits);
    else                                      n_in = DataLength;
  end

  // One parity generator serves both uses: while idle it looks at the incoming word
  // (for ParallParOut at accept), during a frame at the latched word (for the line bit).
  assign pg_data = TxReady ? TxData : data_q;
  assign pg_len  = TxReady ? n_in   : n_q;

  uart_parity_gen #(
    .Width (MaxDataBits),
    .LenW  (LenW)
  ) u_parity (
    .data     (pg_data),
    .len      (pg_len),
    .odd_bit  (pg_odd),
    .even_bit (pg_even)
  );

  assign in_par_none = (ParityType == PAR_NONE0) || (ParityType == PAR_NONE3);
  assign par_en      = (ptype_q == PAR_ODD) || (ptype_q == PAR_EVEN);
  assign par_bit     = (ptype_q == PAR_ODD) ? pg_odd : pg_even;

  // Shift instead of a variable bit-select so the counter width need not match the index width.
  assign data_sh  = data_q >> bitcnt_q;
  assign data_bit = data_sh[0];

  // Next-state and next-output logic; everything advances only on BaudTick once a frame is running.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a value unassigned (no latches).
    state_d   = state_q;
    dout_d    = dout_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    active_d  = active_q;
    done_d    = 1'b0;
    par_out_d = par_out_q;
    case (state_q)
      ST_IDLE: begin
        if (TxValid) begin
          state_d   = ST_SYNC;
          active_d  = 1'b1;
          par_out_d = in_par_none ? pg_odd : 1'b0;
        end
      end
      ST_SYNC: begin
        if (BaudTick) begin
          dout_d  = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (BaudTick) begin
          dout_d   = data_q[0];
          bitcnt_d = LenW'(1);
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (BaudTick) begin
          if (bitcnt_q < n_q) begin
            dout_d   = data_bit;
            bitcnt_d = bitcnt_q + LenW'(1);
          end else if (par_en) begin
            dout_d  = par_bit;
            state_d = ST_PARITY;
          end else begin
            dout_d    = 1'b1;
            stopcnt_d = 1'b0;
            state_d   = ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (BaudTick) begin
          dout_d    = 1'b1;
          stopcnt_d = 1'b0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (BaudTick) begin
          if (stopcnt_q == stop2_q) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
            done_d   = 1'b1;
            bitcnt_d = '0;
          end else begin
            stopcnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      state_q   <= ST_IDLE;
      dout_q    <= 1'b1;
      bitcnt_q  <= '0;
      stopcnt_q <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      par_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      active_q  <= active_d;
      done_q    <= done_d;
      par_out_q <= par_out_d;
    end
  end

  // Capture word and configuration at accept so later input changes cannot disturb the frame.
  always_ff @(posedge Clock) begin
    // NOTE: holding registers are reset too; they are few and this keeps X out of the parity path.
    if (Reset) begin
      data_q  <= '0;
      ptype_q <= PAR_NONE0;
      stop2_q <= 1'b0;
      n_q     <= LenW'(MIN_DATA_BITS);
    end else if (accept) begin
      data_q  <= TxData;
      ptype_q <= parity_e'(ParityType);
      stop2_q <= StopBits;
      n_q     <= n_in;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a frame model pushes expected line bits at
// accept, and a monitor pops and compares them at every BaudTick while a frame runs.
module tb_uart_tx_serializer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       BaudTick;
  logic [1:0] ParityType;
  logic       StopBits;
  logic [3:0] DataLength;
  logic [7:0] TxData;
  logic       TxValid;
  logic       TxReady;
  logic       DataOut;
  logic       ParallParOut;
  logic       ActiveFlag;
  logic       DoneFlag;

  int n_cmp = 0;
  int n_bad = 0;

  logic exp_q[$];
  logic exp_ppo;
  bit   new_frame   = 1'b0;
  bit   gap_armed   = 1'b0;
  int   cyc         = 0;
  int   done_cyc    = 0;
  int   frames_done = 0;
  int   frames_exp  = 0;
  int   tick_div    = 0;

  uart_tx_serializer #(
    .MaxDataBits (8),
    .LenW        (4)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .BaudTick     (BaudTick),
    .ParityType   (ParityType),
    .StopBits     (StopBits),
    .DataLength   (DataLength),
    .TxData       (TxData),
    .TxValid      (TxValid),
    .TxReady      (TxReady),
    .DataOut      (DataOut),
    .ParallParOut (ParallParOut),
    .ActiveFlag   (ActiveFlag),
    .DoneFlag     (DoneFlag)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // BaudTick: one-cycle pulse every fourth clock.
  initial begin
    BaudTick = 1'b0;
    forever begin
      @(negedge Clock);
      tick_div = (tick_div == 3) ? 0 : tick_div + 1;
      BaudTick = (tick_div == 0);
    end
  end

  // Reference framing: start, N data bits LSB first, optional parity, S stop bits.
  task automatic push_frame(input logic [7:0] d, input logic [3:0] len,
                            input logic [1:0] pt, input logic st2);
    int n;
    int ones;
    n    = (len < 5) ? 5 : ((len > 8) ? 8 : int'(len));
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pt == 2'b01) exp_q.push_back((ones % 2) == 0);
    if (pt == 2'b10) exp_q.push_back((ones % 2) == 1);
    exp_q.push_back(1'b1);
    if (st2) exp_q.push_back(1'b1);
    exp_ppo   = (pt == 2'b00 || pt == 2'b11) ? ((ones % 2) == 0) : 1'b0;
    new_frame = 1'b1;
  endtask

  // Monitor: at every tick edge inside a frame, compare the line against the scoreboard;
  // a tick with nothing left to pop is the one that ends the last stop bit.
  initial begin
    logic tick_s, act_s, rst_s, exp_bit;
    forever begin
      @(posedge Clock);
      cyc++;
      tick_s = BaudTick;
      act_s  = ActiveFlag;
      rst_s  = Reset;
      #1;
      if (!rst_s && tick_s && act_s === 1'b1) begin
        if (exp_q.size() > 0) begin
          exp_bit = exp_q.pop_front();
          if (new_frame) begin
            new_frame = 1'b0;
            if (gap_armed) begin
              gap_armed = 1'b0;
              check("idle_gap_cycles", cyc - done_cyc, 4);
            end
          end
          check("line_bit", DataOut, exp_bit);
          check("busy_active", ActiveFlag, 1'b1);
          check("busy_not_ready", TxReady, 1'b0);
        end else begin
          check("end_done", DoneFlag, 1'b1);
          check("end_line_idle", DataOut, 1'b1);
          check("end_inactive", ActiveFlag, 1'b0);
          frames_done++;
          done_cyc = cyc;
          @(negedge Clock);
          @(posedge Clock);
          cyc++;
          #1;
          check("done_one_cycle", DoneFlag, 1'b0);
        end
      end
    end
  end

  // Present a word and wait (bounded) for it to be accepted; optionally leave TxValid high.
  task automatic send(input logic [7:0] d, input logic [3:0] len, input logic [1:0] pt,
                      input logic st2, input bit hold);
    int budget;
    @(negedge Clock);
    TxData     = d;
    DataLength = len;
    ParityType = pt;
    StopBits   = st2;
    TxValid    = 1'b1;
    budget     = 0;
    while (TxReady !== 1'b1 && budget < 2000) begin
      @(negedge Clock);
      budget++;
    end
    if (TxReady !== 1'b1) begin
      check("accept_timeout", 0, 1);
      TxValid = 1'b0;
      return;
    end
    push_frame(d, len, pt, st2);
    @(posedge Clock);
    #1;
    check("accept_ppo", ParallParOut, exp_ppo);
    check("accept_active", ActiveFlag, 1'b1);
    if (!hold) TxValid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int budget;
    budget = 0;
    while (frames_done < target && budget < 2000) begin
      @(negedge Clock);
      budget++;
    end
    check("done_within_budget", frames_done >= target, 1);
  endtask

  initial begin
    logic [7:0] rd;
    logic [3:0] rl;
    logic [1:0] rp;
    logic       rs;
    logic       seen;
    int         budget;

    Reset      = 1'b1;
    TxValid    = 1'b0;
    TxData     = '0;
    DataLength = 4'd8;
    ParityType = 2'b00;
    StopBits   = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_line", DataOut, 1'b1);
    check("rst_ready", TxReady, 1'b1);
    check("rst_active", ActiveFlag, 1'b0);
    check("rst_done", DoneFlag, 1'b0);
    check("rst_ppo", ParallParOut, 1'b0);
    Reset = 1'b0;

    // Ticks with nothing to send leave the line idle.
    repeat (12) @(negedge Clock);
    check("idle_line", DataOut, 1'b1);
    check("idle_active", ActiveFlag, 1'b0);

    // 8N1 0xA5
    send(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0);
    frames_exp++;
    wait_done(frames_exp);
    check("8n1_ppo", ParallParOut, 1'b1);

    // 8E2 0x5A
    send(8'h5A, 4'd8, 2'b10, 1'b1, 1'b0);
    frames_exp++;
    wait_done(frames_exp);
    check("8e2_ppo", ParallParOut, 1'b0);

    // 7O1 0xC1: bit 7 must never reach the line
    send(8'hC1, 4'd7, 2'b01, 1'b0, 1'b0);
    frames_exp++;
    wait_done(frames_exp);

    // Length clamping at both ends
    send(8'hF3, 4'd3, 2'b11, 1'b0, 1'b0);
    frames_exp++;
    wait_done(frames_exp);
    send(8'h96, 4'd12, 2'b10, 1'b1, 1'b0);
    frames_exp++;
    wait_done(frames_exp);

    // Reset while data bit 3 is on the line
    send(8'h5A, 4'd8, 2'b10, 1'b0, 1'b0);
    budget = 0;
    while (exp_q.size() > 6 && budget < 2000) begin
      @(negedge Clock);
      budget++;
    end
    check("reached_bit3", exp_q.size() <= 6, 1);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check("midrst_line", DataOut, 1'b1);
    check("midrst_ready", TxReady, 1'b1);
    check("midrst_done", DoneFlag, 1'b0);
    check("midrst_active", ActiveFlag, 1'b0);
    check("midrst_ppo", ParallParOut, 1'b0);
    @(negedge Clock);
    Reset = 1'b0;
    exp_q.delete();
    new_frame = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge Clock);
      seen = seen | DoneFlag | ActiveFlag;
    end
    check("midrst_quiet", seen, 1'b0);

    // Back-to-back with TxValid held; config changes right after the first accept
    send(8'h3C, 4'd8, 2'b00, 1'b0, 1'b1);
    frames_exp++;
    gap_armed = 1'b0;
    fork
      begin
        // Arm the gap check once the first frame is done, before the second start bit.
        budget = 0;
        while (frames_done < frames_exp && budget < 2000) begin
          @(negedge Clock);
          budget++;
        end
        gap_armed = 1'b1;
      end
    join_none
    send(8'h81, 4'd6, 2'b01, 1'b1, 1'b0);
    frames_exp++;
    wait_done(frames_exp);
    check("b2b_gap_checked", gap_armed, 1'b0);

    // A few random frames
    for (int k = 0; k < 4; k++) begin
      rd = 8'($urandom);
      rl = 4'($urandom_range(3, 12));
      rp = 2'($urandom);
      rs = 1'($urandom);
      send(rd, rl, rp, rs, 1'b0);
      frames_exp++;
      wait_done(frames_exp);
      check("rand_ppo_hold", ParallParOut, exp_ppo);
    end

    repeat (8) @(negedge Clock);
    check("frames_done", frames_done, frames_exp);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
